// File: rtl/regfile_sb.sv
// Parametrised integer register file with pending-write scoreboard, optional
// write-through bypass and a sequenced clear engine that zeroes the file in NREG-1 cycles.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            regwrite,
    input  logic [AW-1:0]   wr,
    input  logic [XLEN-1:0] wd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            sb_set,
    input  logic [AW-1:0]   sb_addr,
    output logic            pend1,
    output logic            pend2,
    input  logic            clr_req,
    output logic            clr_busy
);

    typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   idx_reg, idx_next;
    logic [XLEN-1:0] regf_reg [NREG];
    logic [NREG-1:0] pending_reg, pending_next;
    logic            sweeping, clr_start, wr_en, sb_en, byp1, byp2;

    assign sweeping = (state_reg == SWEEP);
    assign clr_busy = sweeping;
    assign wr_en    = regwrite && (wr != '0) && !sweeping;
    assign sb_en    = sb_set && (sb_addr != '0) && !sweeping;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            pending_reg <= '0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            pending_reg <= pending_next;
        end
    end

    // The sweep starts at register 1 and leaves after writing NREG-1, so the
    // index wraps back to 0 exactly as the engine returns to IDLE.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        clr_start  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (clr_req) begin
                    state_next = SWEEP;
                    idx_next   = AW'(1);
                    clr_start  = 1'b1;
                end
            end
            SWEEP: begin
                idx_next = idx_reg + AW'(1);
                if (idx_reg == AW'(NREG - 1))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Register 0 never qualifies for a write, a sweep or a scoreboard set, so it stays 0.
    genvar gi;
    for (gi = 0; gi < NREG; gi++) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                regf_reg[gi] <= '0;
            else if (sweeping && (idx_reg == AW'(gi)))
                regf_reg[gi] <= '0;
            else if (wr_en && (wr == AW'(gi)))
                regf_reg[gi] <= wd;
        end

        // A same-cycle scoreboard set beats the write-back clear.
        assign pending_next[gi] = clr_start                         ? 1'b0 :
                                  (sb_en && (sb_addr == AW'(gi)))   ? 1'b1 :
                                  (wr_en && (wr == AW'(gi)))        ? 1'b0 :
                                                                      pending_reg[gi];
    end

    assign byp1 = (BYPASS != 0) && wr_en && (wr == rs1);
    assign byp2 = (BYPASS != 0) && wr_en && (wr == rs2);

    assign rd1   = (rs1 == '0) ? '0 : (byp1 ? wd : regf_reg[rs1]);
    assign rd2   = (rs2 == '0) ? '0 : (byp2 ? wd : regf_reg[rs2]);
    assign pend1 = pending_reg[rs1] && !byp1;
    assign pend2 = pending_reg[rs2] && !byp2;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: 32x32 instances with and without bypass share stimulus and
// a behavioural model; a 64x16 instance is exercised with directed steps.
module tb_regfile_sb;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            regwrite = 0, sb_set = 0, clr_req = 0;
    logic [AW-1:0]   wr = '0, rs1 = '0, rs2 = '0, sb_addr = '0;
    logic [31:0]     wd = '0;
    logic [31:0]     rd1, rd2, rd1_nb, rd2_nb;
    logic            pend1, pend2, pend1_nb, pend2_nb, busy, busy_nb;

    logic            w_regwrite = 0, w_sb_set = 0, w_clr_req = 0;
    logic [3:0]      w_wr = '0, w_rs1 = '0, w_rs2 = '0, w_sb_addr = '0;
    logic [63:0]     w_wd = '0, w_rd1, w_rd2;
    logic            w_pend1, w_pend2, w_busy;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .regwrite(regwrite), .wr(wr), .wd(wd),
        .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2), .sb_set(sb_set), .sb_addr(sb_addr),
        .pend1(pend1), .pend2(pend2), .clr_req(clr_req), .clr_busy(busy));

    regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .regwrite(regwrite), .wr(wr), .wd(wd),
        .rs1(rs1), .rs2(rs2), .rd1(rd1_nb), .rd2(rd2_nb), .sb_set(sb_set), .sb_addr(sb_addr),
        .pend1(pend1_nb), .pend2(pend2_nb), .clr_req(clr_req), .clr_busy(busy_nb));

    regfile_sb #(.XLEN(64), .NREG(16), .BYPASS(1)) dut_w (
        .clk(clk), .rst_n(rst_n), .regwrite(w_regwrite), .wr(w_wr), .wd(w_wd),
        .rs1(w_rs1), .rs2(w_rs2), .rd1(w_rd1), .rd2(w_rd2), .sb_set(w_sb_set), .sb_addr(w_sb_addr),
        .pend1(w_pend1), .pend2(w_pend2), .clr_req(w_clr_req), .clr_busy(w_busy));

    // Reference model: architectural contents, pending flags, sweep cycles still to run.
    logic [31:0] m_reg [NREG];
    bit          m_pend [NREG];
    int          m_left, m_idx;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_reg[i]) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_left = 0;
        m_idx  = 0;
    endtask

    function automatic bit qual_write(logic [AW-1:0] a);
        return (m_left == 0) && regwrite && (wr == a) && (a != 0);
    endfunction

    function automatic logic [31:0] exp_rd(logic [AW-1:0] a, bit byp);
        if (a == 0) return '0;
        if (byp && qual_write(a)) return wd;
        return m_reg[a];
    endfunction

    function automatic logic exp_pend(logic [AW-1:0] a, bit byp);
        return m_pend[a] && !(byp && qual_write(a));
    endfunction

    task automatic model_update();
        if (m_left > 0) begin
            m_reg[m_idx] = '0;
            m_idx++;
            m_left--;
        end else begin
            if (regwrite && wr != 0) begin
                m_reg[wr]  = wd;
                m_pend[wr] = 1'b0;
            end
            if (sb_set && sb_addr != 0) m_pend[sb_addr] = 1'b1;
            if (clr_req) begin
                foreach (m_pend[i]) m_pend[i] = 1'b0;
                m_left = NREG - 1;
                m_idx  = 1;
            end
        end
    endtask

    // One clock: compare both 32-bit instances mid-cycle, then advance the model.
    task automatic cycle();
        @(negedge clk);
        chk("rd1",      rd1,      exp_rd(rs1, 1));
        chk("rd2",      rd2,      exp_rd(rs2, 1));
        chk("pend1",    pend1,    exp_pend(rs1, 1));
        chk("pend2",    pend2,    exp_pend(rs2, 1));
        chk("busy",     busy,     m_left > 0);
        chk("rd1_nb",   rd1_nb,   exp_rd(rs1, 0));
        chk("rd2_nb",   rd2_nb,   exp_rd(rs2, 0));
        chk("pend1_nb", pend1_nb, exp_pend(rs1, 0));
        chk("pend2_nb", pend2_nb, exp_pend(rs2, 0));
        chk("busy_nb",  busy_nb,  m_left > 0);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        regwrite = 0; sb_set = 0; clr_req = 0;
    endtask

    task automatic check_all_zero(string tag);
        idle_inputs();
        for (int a = 0; a < NREG; a++) begin
            rs1 = AW'(a);
            rs2 = AW'(NREG - 1 - a);
            #1;
            chk({tag, "_rd1"},    rd1,      '0);
            chk({tag, "_rd2"},    rd2,      '0);
            chk({tag, "_rd1_nb"}, rd1_nb,   '0);
            chk({tag, "_pend1"},  pend1,    '0);
            chk({tag, "_pend2"},  pend2,    '0);
        end
        chk({tag, "_busy"}, busy, '0);
        @(posedge clk);
        #1;
    endtask

    int sweep_len;
    logic [63:0] w_model [16];

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic write / read-back and register 0 discard.
        regwrite = 1; wr = 5; wd = 32'hDEADBEEF; rs1 = 0; rs2 = 0;
        cycle();
        idle_inputs(); rs1 = 5;
        #1 chk("x5_readback", rd1, 32'hDEADBEEF);
        regwrite = 1; wr = 0; wd = 32'h1234; rs1 = 0;
        cycle();
        idle_inputs();
        #1 chk("x0_zero", rd1, 32'h0);

        // Same-cycle bypass vs. registered visibility.
        regwrite = 1; wr = 7; wd = 32'hA5A5A5A5; rs2 = 7;
        #1 chk("bypass_rd2", rd2, 32'hA5A5A5A5);
        chk("nobypass_old", rd2_nb, 32'h0);
        cycle();
        idle_inputs();
        #1 chk("nobypass_new", rd2_nb, 32'hA5A5A5A5);

        // Scoreboard set, masking by write, set-wins collision.
        sb_set = 1; sb_addr = 9; rs1 = 9;
        #1 chk("sb_not_yet", pend1, 1'b0);
        cycle();
        idle_inputs();
        #1 chk("sb_pending", pend1, 1'b1);
        regwrite = 1; wr = 9; wd = 32'h99;
        #1 chk("sb_masked", pend1, 1'b0);
        chk("sb_nb_held", pend1_nb, 1'b1);
        cycle();
        idle_inputs();
        #1 chk("sb_cleared", pend1, 1'b0);
        chk("sb_nb_cleared", pend1_nb, 1'b0);
        regwrite = 1; wr = 9; wd = 32'h77; sb_set = 1; sb_addr = 9;
        cycle();
        idle_inputs();
        #1 chk("sb_set_wins", pend1, 1'b1);

        // Randomised traffic, including occasional clears.
        for (int n = 0; n < 400; n++) begin
            regwrite = 1'($urandom_range(0, 1));
            wr       = AW'($urandom_range(0, NREG - 1));
            wd       = $urandom;
            rs1      = ($urandom_range(0, 3) == 0) ? wr : AW'($urandom_range(0, NREG - 1));
            rs2      = AW'($urandom_range(0, NREG - 1));
            sb_set   = 1'($urandom_range(0, 2) == 0);
            sb_addr  = ($urandom_range(0, 3) == 0) ? wr : AW'($urandom_range(0, NREG - 1));
            clr_req  = 1'($urandom_range(0, 59) == 0);
            cycle();
        end
        idle_inputs();
        repeat (NREG) cycle();

        // Full clear with a dropped mid-sweep write.
        for (int a = 1; a < NREG; a++) begin
            regwrite = 1; wr = AW'(a); wd = 32'h01010101 * a + 1; sb_set = 1; sb_addr = AW'(a);
            cycle();
        end
        idle_inputs();
        clr_req = 1;
        cycle();
        clr_req = 0;
        sweep_len = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy) sweep_len++;
            regwrite = (k == 5); wr = 3; wd = 32'hBAD0BAD0; rs1 = 3;
            cycle();
        end
        chk("sweep_len", sweep_len, 31);
        check_all_zero("after_clear");

        // Asynchronous reset in the middle of a sweep.
        for (int a = 1; a < NREG; a++) begin
            regwrite = 1; wr = AW'(a); wd = $urandom | 32'h1;
            cycle();
        end
        idle_inputs();
        clr_req = 1;
        cycle();
        clr_req = 0;
        repeat (9) cycle();
        rst_n = 1'b0;
        model_reset();
        #1 chk("rst_busy", busy, 1'b0);
        check_all_zero("mid_sweep_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clr_req = 1;
        cycle();
        clr_req = 0;
        sweep_len = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy) sweep_len++;
            cycle();
        end
        chk("resweep_len", sweep_len, 31);

        // 64-bit, 16-register instance.
        foreach (w_model[i]) w_model[i] = '0;
        w_regwrite = 1; w_wr = 15; w_wd = 64'hFFFF_0000_FFFF_0001;
        @(posedge clk); #1;
        w_model[15] = 64'hFFFF_0000_FFFF_0001;
        w_regwrite = 0; w_rs1 = 15;
        #1 chk("w_x15", w_rd1, 64'hFFFF_0000_FFFF_0001);
        for (int n = 0; n < 12; n++) begin
            w_regwrite = 1; w_wr = 4'($urandom_range(0, 15)); w_wd = {$urandom, $urandom};
            @(posedge clk); #1;
            if (w_wr != 0) w_model[w_wr] = w_wd;
        end
        w_regwrite = 0;
        for (int a = 0; a < 16; a++) begin
            w_rs1 = 4'(a); w_rs2 = 4'(15 - a);
            #1 chk("w_rd1", w_rd1, w_model[a]);
            chk("w_rd2", w_rd2, w_model[15 - a]);
        end
        w_clr_req = 1;
        @(posedge clk); #1;
        w_clr_req = 0;
        sweep_len = 0;
        for (int k = 0; k < 30; k++) begin
            if (w_busy) sweep_len++;
            @(posedge clk); #1;
        end
        chk("w_sweep_len", sweep_len, 15);
        for (int a = 0; a < 16; a++) begin
            w_rs1 = 4'(a);
            #1 chk("w_clear", w_rd1, 64'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file for the single-cycle/pipelined RISC-V core, successor to the fixed 32x32 file. It adds configurable width and depth, optional write-to-read bypass, a per-register scoreboard of pending writes for hazard detection, and a sequenced clear engine that zeroes the file without a reset. It sits between decode (read ports, scoreboard set) and writeback (write port).

## Interface
- XLEN, 32, data width of each register
- NREG, 32, number of registers (power of two, >= 4); address width AW = log2(NREG)
- BYPASS, 1, 1 = same-cycle write-through to read ports; 0 = reads show old value until the cycle after the write

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- regwrite  in  1  write enable
- wr  in  AW  write address
- wd  in  XLEN  write data
- rs1, rs2  in  AW  read addresses
- rd1, rd2  out  XLEN  read data (combinational)
- sb_set  in  1  mark register sb_addr as having a write in flight
- sb_addr  in  AW  scoreboard set address
- pend1, pend2  out  1  rs1/rs2 has a write in flight (combinational)
- clr_req  in  1  request clear of the whole file
- clr_busy  out  1  clear sweep in progress

## Operation
- Register 0 reads as 0 always; writes to 0 are dropped; sb_set to 0 is dropped; pending[0] is always 0.
- Write: regwrite=1, wr!=0, not sweeping -> regf[wr] <= wd and pending[wr] <= 0 on the edge.
- Read: rdN = 0 if rsN==0; else wd if BYPASS=1 and regwrite and wr==rsN and not sweeping; else regf[rsN].
- Scoreboard: sb_set=1, sb_addr!=0 -> pending[sb_addr] <= 1. If sb_set and regwrite target the same register in the same cycle, set wins (pending ends at 1).
- pendN = pending[rsN]. With BYPASS=1 the bit is masked to 0 when a qualifying write to rsN occurs in the same cycle. With BYPASS=0 it stays 1 until the cycle after the write.
- Clear engine, states IDLE and SWEEP:
  - IDLE -> SWEEP on clr_req=1. In that same edge all pending bits clear and the index loads 1.
  - In SWEEP, each cycle: regf[index] <= 0, index increments. After writing NREG-1, return to IDLE.
  - clr_req is ignored while in SWEEP.
  - While in SWEEP, regwrite and sb_set are ignored, bypass is disabled, and reads return the current array contents, which are partially cleared.
- Reset (asserted at any time, including mid-sweep): all registers 0, all pending 0, state IDLE, index 0.

## Timing
- Read path and pend outputs are combinational from rs1/rs2, the array, and the write port. Write latency is 1 edge.
- Reset values: rd1=rd2=0 for all addresses, pend1=pend2=0, clr_busy=0.
- clr_busy = (state==SWEEP), high for exactly NREG-1 cycles starting the cycle after the clr_req edge.
- After clr_busy falls, every register reads 0, and writes and sb_set are accepted that same cycle.
- Index wraps only by returning to IDLE; it never writes register 0.

## Test plan
- Reset then write: write 0xDEADBEEF to x5; next cycle rs1=5 -> rd1=0xDEADBEEF. Write 0x1234 to x0 -> rd1 for rs1=0 remains 0.
- Bypass, BYPASS=1: regwrite wr=7 wd=0xA5A5A5A5 with rs2=7 in the same cycle -> rd2=0xA5A5A5A5 combinationally. With BYPASS=0, same stimulus -> rd2 shows the old value, then 0xA5A5A5A5 after the edge.
- Scoreboard: sb_set x9 -> pend1=1 for rs1=9 from the next cycle. Write x9 -> pend1 masked in the write cycle (BYPASS=1) and 0 after the edge. sb_set and regwrite both on x9 in one cycle -> pend1 stays 1.
- Clear: fill x1..x31 with nonzero values, pulse clr_req -> clr_busy high 31 cycles. A regwrite to x3 mid-sweep is dropped, all reads return 0 afterward, and all pend bits are 0.
- Reset mid-sweep: assert rst_n=0 at sweep cycle 10 -> clr_busy=0 immediately, all reads 0. After release, a new clr_req gives a full 31-cycle sweep.
- Parameters XLEN=64, NREG=16: write 0xFFFF_0000_FFFF_0001 to x15 and read it back. A clear sweep lasts 15 cycles.
